// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: channel states {A,B}, direction
// constants, transition classes and the pure transition-decode function.
package quad_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_UP   = 2'd1,
    TR_DN   = 2'd2,
    TR_ERR  = 2'd3
  } trans_t;

  // PH_FILL waits until the synchronizers carry real samples, then primes prev.
  typedef enum logic {
    PH_FILL = 1'b0,
    PH_RUN  = 1'b1
  } phase_t;

  function automatic trans_t decode(input logic [1:0] prev, input logic [1:0] cur);
    trans_t tr;
    if (prev == cur) begin
      tr = TR_NONE;
    end else if ((prev == S00 && cur == S01) || (prev == S01 && cur == S11) ||
                 (prev == S11 && cur == S10) || (prev == S10 && cur == S00)) begin
      tr = TR_UP;
    end else if ((prev ^ cur) == 2'b11) begin
      tr = TR_ERR;
    end else begin
      tr = TR_DN;
    end
    return tr;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Bundle of the decoder's functional signals plus the phase debug output.
// Handshake: none; inputs are free-running levels, step/err are one-cycle pulses.
interface quad_decoder_if #(
  parameter int WIDTH = 8
);
  import quad_pkg::*;

  logic             a_in;
  logic             b_in;
  logic             clr;
  logic             step;
  logic             up_down;
  logic [WIDTH-1:0] count;
  logic             err;
  logic             err_flag;
  phase_t           phase;

  modport master (
    output a_in, b_in, clr,
    input  step, up_down, count, err, err_flag, phase
  );

  modport slave (
    input  a_in, b_in, clr,
    output step, up_down, count, err, err_flag, phase
  );
endinterface

// File: rtl/quad_decoder_sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, decodes transitions against the previous
// state and maintains a wrapping position counter with a sticky error flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  quad_decoder_if.slave bus
);

  localparam int            FW        = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(SYNC_STAGES);

  logic a_sync, b_sync;
  logic [1:0] cur;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_a (.clk(clk), .rst_n(rst_n), .d_i(bus.a_in), .q_o(a_sync));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_b (.clk(clk), .rst_n(rst_n), .d_i(bus.b_in), .q_o(b_sync));

  assign cur = {a_sync, b_sync};

  phase_t           phase_q, phase_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [1:0]       prev_q, prev_d;
  logic             step_q, step_d;
  logic             up_down_q, up_down_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             err_flag_q, err_flag_d;
  trans_t           tr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_FILL;
      fill_q     <= '0;
      prev_q     <= S00;
      step_q     <= 1'b0;
      up_down_q  <= DIR_DN;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      fill_q     <= fill_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      up_down_q  <= up_down_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    fill_d     = fill_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    up_down_d  = up_down_q;
    count_d    = count_q;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;
    tr         = TR_NONE;

    unique case (phase_q)
      PH_FILL: begin
        // cur only reflects a real input sample once every stage has been loaded
        if (fill_q == FILL_LAST) begin
          prev_d  = cur;
          phase_d = PH_RUN;
        end else begin
          fill_d = fill_q + FW'(1);
        end
      end
      PH_RUN: begin
        prev_d = cur;
        tr     = decode(prev_q, cur);
        unique case (tr)
          TR_UP: begin
            step_d    = 1'b1;
            up_down_d = DIR_UP;
            count_d   = count_q + WIDTH'(1);
          end
          TR_DN: begin
            step_d    = 1'b1;
            up_down_d = DIR_DN;
            count_d   = count_q - WIDTH'(1);
          end
          TR_ERR: begin
            err_d      = 1'b1;
            err_flag_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: phase_d = PH_FILL;
    endcase

    // clear overrides the count, but a coincident error keeps the flag set
    if (bus.clr) begin
      count_d = '0;
      if (!err_d) err_flag_d = 1'b0;
    end
  end

  assign bus.step     = step_q;
  assign bus.up_down  = up_down_q;
  assign bus.count    = count_q;
  assign bus.err      = err_q;
  assign bus.err_flag = err_flag_q;
  assign bus.phase    = phase_q;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter WIDTH, default 8, is the position counter width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth per channel, minimum 2.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset, deasserted synchronously.
REQ-005 a_in  input  1  quadrature channel A, asynchronous to clk.
REQ-006 b_in  input  1  quadrature channel B, asynchronous to clk.
REQ-007 clr  input  1  synchronous clear of count and err_flag, active high.
REQ-008 step  output  1  one-cycle pulse per valid quadrature transition.
REQ-009 up_down  output  1  direction of the last valid transition: 1 = up, 0 = down.
REQ-010 count  output  WIDTH  signed-agnostic position counter.
REQ-011 err  output  1  one-cycle pulse on an illegal transition (both channels changed).
REQ-012 err_flag  output  1  sticky error indicator.

Function
REQ-013 Each channel SHALL pass through a SYNC_STAGES flop synchronizer; the synchronized pair {A,B} is the current state, and a register holds the previous state.
REQ-014 Forward sequence 00->01->11->10->00 SHALL register step=1, up_down=1, count=count+1.
REQ-015 Reverse sequence 00->10->11->01->00 SHALL register step=1, up_down=0, count=count-1.
REQ-016 An unchanged state SHALL leave count and up_down unchanged, with step=0 and err=0.
REQ-017 A change in both bits SHALL register err=1 and err_flag=1; count, up_down and step=0 are unchanged.
REQ-018 Latency: with SYNC_STAGES=2, a level change stable at rising edge N SHALL appear on step, up_down, count and err after edge N+2.
REQ-019 step and err SHALL be high for exactly one clk cycle per event and SHALL never be high together.
REQ-020 count SHALL wrap modulo 2^WIDTH: all-ones +1 -> 0 and 0 -1 -> all-ones, with no flag.
REQ-021 clr=1 SHALL set count=0 and err_flag=0 on that edge.
REQ-022 When clr and a valid transition coincide, step/up_down SHALL still be reported and count SHALL become 0.
REQ-023 When clr and an illegal transition coincide, err SHALL pulse and err_flag SHALL become 1; set wins over clear.
REQ-024 The first synchronized sample after reset SHALL only load the previous-state register, with no step or err, whatever the input levels are.

Reset
REQ-025 While rst_n=0: synchronizer flops=0, previous state=00, init flag cleared, count=0, step=0, up_down=0, err=0, err_flag=0.
REQ-026 Assertion of rst_n mid-sequence SHALL abort any in-flight transition; no step or err SHALL be emitted for it after release.

Structure
REQ-027 Package quad_pkg SHALL hold the 2-bit state encodings (S00, S01, S11, S10) and the direction constants DIR_UP=1 and DIR_DN=0.
REQ-028 A sub-module sync_ff (parameterized depth, 1-bit, async active-low reset) SHALL be instantiated once per channel.
REQ-029 Transition decode SHALL be a pure function of (previous, current) state using quad_pkg constants.

Verification
REQ-030 Reset released with a_in=1, b_in=1 -> no step and no err; count=0.
REQ-031 From 00, four forward steps (01, 11, 10, 00), each held 4 cycles -> 4 step pulses, up_down=1, count=4, each pulse arriving 3 edges after the input change.
REQ-032 With count=0, one reverse step 00->10 -> count=255 (WIDTH=8), up_down=0; then one forward step -> count=0.
REQ-033 Jump 00->11 in one cycle -> err pulse for 1 cycle, err_flag=1, count unchanged; then clr -> err_flag=0, count=0.
REQ-034 clr asserted on the same edge as a registered forward transition -> step=1, up_down=1, count=0.
REQ-035 rst_n pulsed low for 1 cycle, 1 cycle after an input change -> no step or err afterward; all outputs are at reset values.
